// File: rtl/selector_pkg.sv
// Shared types and size helpers for the board selector.
package selector_pkg;

  typedef enum logic {
    ACTIVO = 1'b0,
    LLENO  = 1'b1
  } estado_t;

  localparam int NUM_BOTONES = 5;
  localparam int B_ARRIBA    = 0;
  localparam int B_ABAJO     = 1;
  localparam int B_IZQ       = 2;
  localparam int B_DER       = 3;
  localparam int B_ELIGE     = 4;

  // Width of the cell index for an n x n board.
  function automatic int calc_w(input int n);
    return (n * n > 1) ? $clog2(n * n) : 1;
  endfunction

  // Width of a row or column counter.
  function automatic int calc_rw(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Row-major index of the centre cell.
  function automatic int calc_centro(input int n);
    return (n / 2) * n + n / 2;
  endfunction

endpackage

// File: rtl/detector_flanco.sv
// Registered rising-edge detector for one debounced button. A button already
// high when reset is released must first be seen low before it can fire.
module detector_flanco (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic flanco
);

  logic previo;
  logic armado;

  // History bit plus an arm flag that sets once the input has been seen low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      previo <= 1'b0;
      armado <= 1'b0;
    end else begin
      previo <= d;
      if (!d) armado <= 1'b1;
    end
  end

  assign flanco = d & ~previo & armado;

endmodule

// File: rtl/selector_tablero.sv
// Board cursor and cell-ownership tracker for an N x N two-player board.
module selector_tablero
  import selector_pkg::*;
#(
  parameter int N    = 3,
  parameter bit WRAP = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 boton_arriba,
  input  logic                 boton_abajo,
  input  logic                 boton_izq,
  input  logic                 boton_der,
  input  logic                 boton_elige,
  input  logic                 turno_p1,
  input  logic                 limpiar,
  output logic [calc_w(N)-1:0] cuadro,
  output logic [N*N-1:0]       p1_mm,
  output logic [N*N-1:0]       p2_mm,
  output logic                 jugada_valida,
  output logic                 jugada_invalida,
  output logic                 tablero_lleno
);

  localparam int NC     = N * N;
  localparam int W      = calc_w(N);
  localparam int RW     = calc_rw(N);
  localparam int CENTRO = calc_centro(N);

  localparam logic [RW-1:0] FILA_C = RW'(CENTRO / N);
  localparam logic [RW-1:0] COL_C  = RW'(CENTRO % N);
  localparam logic [RW-1:0] ULT    = RW'(N - 1);
  localparam logic [RW-1:0] CERO   = '0;
  localparam logic [RW-1:0] UNO    = RW'(1);
  localparam logic [NC-1:0] BIT0   = NC'(1);

  logic [NUM_BOTONES-1:0] botones;
  logic [NUM_BOTONES-1:0] flancos;
  logic [3:0]             dirs;
  logic                   mover;

  logic [RW-1:0] fila_q, fila_d, col_q, col_d;
  logic [NC-1:0] p1_d, p2_d, mascara;
  logic          ocupado;
  logic          val_d, inv_d;
  estado_t       estado_q, estado_d;

  assign botones = {boton_elige, boton_der, boton_izq, boton_abajo, boton_arriba};

  detector_flanco u_flanco [NUM_BOTONES-1:0] (
    .clk    (clk),
    .rst_n  (rst_n),
    .d      (botones),
    .flanco (flancos)
  );

  // A move needs exactly one direction edge and no select edge.
  assign dirs    = flancos[B_DER:B_ARRIBA];
  assign mover   = $onehot(dirs) & ~flancos[B_ELIGE];
  assign cuadro  = W'(fila_q) * W'(N) + W'(col_q);
  assign mascara = BIT0 << cuadro;
  assign ocupado = |((p1_mm | p2_mm) & mascara);

  // Next cursor, maps and result pulses; clear beats select beats moves.
  always_comb begin
    fila_d = fila_q;
    col_d  = col_q;
    p1_d   = p1_mm;
    p2_d   = p2_mm;
    val_d  = 1'b0;
    inv_d  = 1'b0;
    if (limpiar) begin
      fila_d = FILA_C;
      col_d  = COL_C;
      p1_d   = '0;
      p2_d   = '0;
    end else if (flancos[B_ELIGE]) begin
      if (estado_q == ACTIVO && !ocupado) begin
        if (turno_p1) p1_d = p1_mm | mascara;
        else          p2_d = p2_mm | mascara;
        val_d = 1'b1;
      end else begin
        inv_d = 1'b1;
      end
    end else if (mover) begin
      if (dirs[B_ARRIBA]) begin
        if (fila_q == CERO) fila_d = WRAP ? ULT : fila_q;
        else                fila_d = fila_q - UNO;
      end else if (dirs[B_ABAJO]) begin
        if (fila_q == ULT)  fila_d = WRAP ? CERO : fila_q;
        else                fila_d = fila_q + UNO;
      end else if (dirs[B_IZQ]) begin
        if (col_q == CERO)  col_d = WRAP ? ULT : col_q;
        else                col_d = col_q - UNO;
      end else begin
        if (col_q == ULT)   col_d = WRAP ? CERO : col_q;
        else                col_d = col_q + UNO;
      end
    end
  end

  // Cursor counters, ownership maps and one-cycle result pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fila_q          <= FILA_C;
      col_q           <= COL_C;
      p1_mm           <= '0;
      p2_mm           <= '0;
      jugada_valida   <= 1'b0;
      jugada_invalida <= 1'b0;
    end else begin
      fila_q          <= fila_d;
      col_q           <= col_d;
      p1_mm           <= p1_d;
      p2_mm           <= p2_d;
      jugada_valida   <= val_d;
      jugada_invalida <= inv_d;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) estado_q <= ACTIVO;
    else        estado_q <= estado_d;
  end

  // FSM next state: goes full on the edge that fills the last cell.
  always_comb begin
    estado_d = estado_q;
    if (limpiar)                                 estado_d = ACTIVO;
    else if (estado_q == ACTIVO && &(p1_d | p2_d)) estado_d = LLENO;
  end

  // FSM outputs.
  always_comb begin
    tablero_lleno = (estado_q == LLENO);
  end

endmodule

// File: tb/tb_selector_tablero.sv
// Scoreboard bench: a WRAP=1 board driven through a directed game, plus a
// WRAP=0 board that only sees the up button.
module tb_selector_tablero;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [4:0] btn = '0;     // {elige, der, izq, abajo, arriba}
  logic       turno = 1'b0;
  logic       limpiar = 1'b0;
  logic       arr2 = 1'b0;

  logic [3:0] cuadro, cuadro_b;
  logic [8:0] p1, p2, p1_b, p2_b;
  logic       val, inv, lleno, val_b, inv_b, lleno_b;

  always #5 clk = ~clk;

  selector_tablero #(.N(3), .WRAP(1'b1)) dut (
    .clk(clk), .rst_n(rst_n),
    .boton_arriba(btn[0]), .boton_abajo(btn[1]), .boton_izq(btn[2]),
    .boton_der(btn[3]), .boton_elige(btn[4]),
    .turno_p1(turno), .limpiar(limpiar),
    .cuadro(cuadro), .p1_mm(p1), .p2_mm(p2),
    .jugada_valida(val), .jugada_invalida(inv), .tablero_lleno(lleno)
  );

  selector_tablero #(.N(3), .WRAP(1'b0)) dut_sat (
    .clk(clk), .rst_n(rst_n),
    .boton_arriba(arr2), .boton_abajo(1'b0), .boton_izq(1'b0),
    .boton_der(1'b0), .boton_elige(1'b0),
    .turno_p1(1'b0), .limpiar(limpiar),
    .cuadro(cuadro_b), .p1_mm(p1_b), .p2_mm(p2_b),
    .jugada_valida(val_b), .jugada_invalida(inv_b), .tablero_lleno(lleno_b)
  );

  typedef struct {
    logic [3:0] c;
    logic [8:0] e1;
    logic [8:0] e2;
    logic       ll;
    logic [3:0] cs;
  } exp_t;

  exp_t  eq[$];
  string nq[$];
  bit    pq[$];     // 1 = jugada_valida expected, 0 = jugada_invalida
  bit    muestra = 1'b0;
  bit    fin = 1'b0;
  int    checks = 0;
  int    errors = 0;

  // Monitor: checks every result pulse against the pulse queue and every
  // requested snapshot against the state queue.
  always @(negedge clk) begin
    exp_t  e;
    string nm;
    bit    pe;
    if (val && inv) begin
      checks++; errors++;
      $display("FAIL pulsos_simultaneos: valida=%b invalida=%b, required not both", val, inv);
    end
    if (val || inv) begin
      checks++;
      if (pq.size() == 0) begin
        errors++;
        $display("FAIL pulso_inesperado: valida=%b invalida=%b, required none", val, inv);
      end else begin
        pe = pq.pop_front();
        if (val !== pe) begin
          errors++;
          $display("FAIL tipo_pulso: valida=%b invalida=%b, required valida=%b", val, inv, pe);
        end
      end
    end
    if (muestra && eq.size() != 0) begin
      e  = eq.pop_front();
      nm = nq.pop_front();
      checks++;
      if (cuadro !== e.c || p1 !== e.e1 || p2 !== e.e2 || lleno !== e.ll ||
          cuadro_b !== e.cs || {p1_b, p2_b, val_b, inv_b, lleno_b} !== 21'd0) begin
        errors++;
        $display("FAIL %s: cuadro=%0d p1=%h p2=%h lleno=%b sat=%0d/%h/%h/%b%b%b, required cuadro=%0d p1=%h p2=%h lleno=%b sat=%0d/0/0/000",
                 nm, cuadro, p1, p2, lleno, cuadro_b, p1_b, p2_b, val_b, inv_b, lleno_b,
                 e.c, e.e1, e.e2, e.ll, e.cs);
      end
    end
    if (fin) begin
      checks++;
      if (pq.size() != 0) begin
        errors++;
        $display("FAIL pulso_faltante: %0d pending, required 0", pq.size());
      end
    end
  end

  task automatic chk(input logic [3:0] c, input logic [8:0] e1, e2,
                     input logic ll, input logic [3:0] cs, input string nm);
    exp_t e;
    e.c = c; e.e1 = e1; e.e2 = e2; e.ll = ll; e.cs = cs;
    eq.push_back(e);
    nq.push_back(nm);
    muestra = 1'b1;
    @(negedge clk); #1;
    muestra = 1'b0;
  endtask

  // One directed vector: apply buttons for 'hold' edges, release, check,
  // then one idle cycle so the next press is a fresh edge.
  task automatic st(input logic [4:0] b, input logic t, l, input int hold,
                    input logic [3:0] c, input logic [8:0] e1, e2,
                    input logic ll, input logic [3:0] cs, input int pl,
                    input string nm);
    turno = t; btn = b; limpiar = l; arr2 = b[0];
    if (pl == 1)      pq.push_back(1'b1);
    else if (pl == 2) pq.push_back(1'b0);
    repeat (hold) @(posedge clk);
    #1;
    btn = '0; limpiar = 1'b0; arr2 = 1'b0;
    chk(c, e1, e2, ll, cs, nm);
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not end, required finish");
    $fatal(1);
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk(4, 9'h000, 9'h000, 0, 4, "reset");
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk(4, 9'h000, 9'h000, 0, 4, "post_reset");
    @(posedge clk); #1;

    //  buttons   t  l hold c  p1      p2      ll cs pl name
    st(5'b00001, 0, 0, 1,  1, 9'h000, 9'h000, 0, 1, 0, "arriba_4_1");
    st(5'b00001, 0, 0, 1,  7, 9'h000, 9'h000, 0, 1, 0, "arriba_wrap_7");
    st(5'b00010, 0, 0, 1,  1, 9'h000, 9'h000, 0, 1, 0, "abajo_wrap_1");
    st(5'b00010, 0, 0, 1,  4, 9'h000, 9'h000, 0, 1, 0, "abajo_4");
    st(5'b01000, 0, 0, 1,  5, 9'h000, 9'h000, 0, 1, 0, "der_5");
    st(5'b01000, 0, 0, 1,  3, 9'h000, 9'h000, 0, 1, 0, "der_wrap_3");
    st(5'b00100, 0, 0, 1,  5, 9'h000, 9'h000, 0, 1, 0, "izq_wrap_5");
    st(5'b00001, 0, 0, 10, 2, 9'h000, 9'h000, 0, 1, 0, "arriba_sostenido");
    st(5'b00101, 0, 0, 1,  2, 9'h000, 9'h000, 0, 1, 0, "dos_direcciones");
    st(5'b00010, 0, 0, 1,  5, 9'h000, 9'h000, 0, 1, 0, "abajo_5");
    st(5'b00100, 0, 0, 1,  4, 9'h000, 9'h000, 0, 1, 0, "izq_4");
    st(5'b10000, 1, 0, 1,  4, 9'h010, 9'h000, 0, 1, 1, "elige_p1_4");
    st(5'b10000, 0, 0, 1,  4, 9'h010, 9'h000, 0, 1, 2, "elige_ocupado");
    st(5'b11000, 0, 0, 1,  4, 9'h010, 9'h000, 0, 1, 2, "elige_mas_der");
    st(5'b00001, 0, 0, 1,  1, 9'h010, 9'h000, 0, 1, 0, "ir_1");
    st(5'b00100, 0, 0, 1,  0, 9'h010, 9'h000, 0, 1, 0, "ir_0");
    st(5'b10000, 0, 0, 1,  0, 9'h010, 9'h001, 0, 1, 1, "p2_0");
    st(5'b01000, 0, 0, 1,  1, 9'h010, 9'h001, 0, 1, 0, "ir_1b");
    st(5'b10000, 1, 0, 1,  1, 9'h012, 9'h001, 0, 1, 1, "p1_1");
    st(5'b01000, 0, 0, 1,  2, 9'h012, 9'h001, 0, 1, 0, "ir_2");
    st(5'b10000, 0, 0, 1,  2, 9'h012, 9'h005, 0, 1, 1, "p2_2");
    st(5'b00010, 0, 0, 1,  5, 9'h012, 9'h005, 0, 1, 0, "ir_5");
    st(5'b10000, 1, 0, 1,  5, 9'h032, 9'h005, 0, 1, 1, "p1_5");
    st(5'b00100, 0, 0, 1,  4, 9'h032, 9'h005, 0, 1, 0, "ir_4");
    st(5'b00100, 0, 0, 1,  3, 9'h032, 9'h005, 0, 1, 0, "ir_3");
    st(5'b10000, 0, 0, 1,  3, 9'h032, 9'h00D, 0, 1, 1, "p2_3");
    st(5'b00010, 0, 0, 1,  6, 9'h032, 9'h00D, 0, 1, 0, "ir_6");
    st(5'b10000, 1, 0, 1,  6, 9'h072, 9'h00D, 0, 1, 1, "p1_6");
    st(5'b01000, 0, 0, 1,  7, 9'h072, 9'h00D, 0, 1, 0, "ir_7");
    st(5'b10000, 0, 0, 1,  7, 9'h072, 9'h08D, 0, 1, 1, "p2_7");
    st(5'b01000, 0, 0, 1,  8, 9'h072, 9'h08D, 0, 1, 0, "ir_8");
    st(5'b10000, 1, 0, 1,  8, 9'h172, 9'h08D, 1, 1, 1, "p1_8_lleno");
    st(5'b10000, 0, 0, 1,  8, 9'h172, 9'h08D, 1, 1, 2, "elige_lleno");
    st(5'b00001, 0, 0, 1,  5, 9'h172, 9'h08D, 1, 1, 0, "mover_en_lleno");
    st(5'b10000, 1, 1, 1,  4, 9'h000, 9'h000, 0, 4, 0, "limpiar");
    st(5'b01000, 0, 0, 1,  5, 9'h000, 9'h000, 0, 4, 0, "der_tras_limpiar");
    st(5'b10000, 1, 0, 1,  5, 9'h020, 9'h000, 0, 4, 1, "p1_5_nuevo");

    // Reset in the middle of a game with der held through release.
    btn = 5'b01000;
    @(posedge clk); #1;
    chk(3, 9'h020, 9'h000, 0, 4, "der_antes_reset");
    rst_n = 1'b0;
    chk(4, 9'h000, 9'h000, 0, 4, "reset_asincrono");
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk(4, 9'h000, 9'h000, 0, 4, "der_sostenido_tras_reset");
    btn = '0;
    repeat (2) @(posedge clk);
    #1;
    btn = 5'b01000;
    @(posedge clk); #1;
    btn = '0;
    chk(5, 9'h000, 9'h000, 0, 4, "der_repulsado");

    fin = 1'b1;
    @(negedge clk); #1;
    fin = 1'b0;
    @(posedge clk); #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
